event_window_scheduler: RTL and testbench
=========================================

# event_window_scheduler

Event-driven window scheduler between pipeline stages of the event-based corner-detection chain (Sobel 3×3, Gauss 7×7, NMS 5×5). It stores every incoming pixel event in a 256×256 frame memory and queues the event address as a window centre. For each queued centre it gathers the (2·HALF_WINDOW_SIZE+1)² neighbourhood from memory and hands the packed window to the downstream kernel. One parameterised block covers all three window sizes.

## Interface
- DATA_WIDTH, default 4: bits per stored pixel value.
- HALF_WINDOW_SIZE, default 1: H; window side S = 2H+1, window size N = S².
- TODO_WINDOW_FIFO_DEPTH, default 256: centre-address FIFO depth (power of two).
- Reset: one clock domain; rst_n is synchronous and active-high (asserted = 1), despite the name.
- clk  in  1  clock; everything samples on the rising edge.
- rst_n  in  1  synchronous active-high reset.
- in_event_value  in  DATA_WIDTH  pixel value of the incoming event.
- in_event_addr  in  16  event address; row = [15:8], col = [7:0].
- in_event_valid  in  1  event present.
- ready_for_new_event  out  1  scheduler can accept an event this cycle.
- window_req  in  1  downstream ready to take a window.
- out_window_value  out  N·DATA_WIDTH  packed window.
- out_window_addr  out  16  centre address of the window.
- out_window_valid  out  1  window presented.

## Operation
- Frame memory: 65536 × DATA_WIDTH, one write port and one synchronous-read port (1-cycle read latency).
  - Contents initialise to 0 at configuration.
  - Reset does not clear memory.
- Event accept: occurs when in_event_valid && ready_for_new_event at a rising edge.
  - mem[in_event_addr] ← in_event_value.
  - in_event_addr is pushed into the TODO FIFO.
  - Events presented while ready_for_new_event = 0 are dropped. Upstream must hold them.
- ready_for_new_event = !fifo_full, combinational from FIFO state. No push occurs when the FIFO is full, even if a pop happens in the same cycle.
- FSM states:
  - IDLE: if FIFO is non-empty, pop the centre (r0, c0), latch it to out_window_addr, go to FETCH.
  - FETCH: issue N reads, one per cycle, in row-major order (dr = −H..H outer, dc = −H..H inner).
    - Neighbour at (r0+dr, c0+dc).
    - If the row or column falls outside 0..255, there is no wrap-around: the element is forced to 0 and no read is needed.
    - After the last read data returns, go to VALID.
  - VALID: hold out_window_valid = 1 with stable value and addr until window_req = 1 at an edge, then go to IDLE.
- Packing: element k = (dr+H)·S + (dc+H) occupies out_window_value[k·DATA_WIDTH +: DATA_WIDTH]. Top-left is at the LSBs; the centre is k = (N−1)/2.
- Event writes continue during FETCH and VALID.
  - A write to a pixel not yet read appears in the window.
  - A write to an already-read pixel does not.
  - A window is not updated once VALID.
- Duplicate centres are not merged. Each accepted event yields exactly one window, in FIFO order.

## Timing
- Reset values: out_window_valid = 0, out_window_addr = 0, out_window_value = 0, FIFO empty, FSM = IDLE, ready_for_new_event = 1 in the cycle after reset deasserts.
- Latency: event accepted at edge t, with FSM in IDLE and FIFO empty:
  - pop at edge t+1;
  - reads at edges t+1 .. t+N;
  - out_window_valid = 1 after edge t+N+2.
  - For H=1 that is 11 cycles; H=2 is 27; H=3 is 51.
- Handshake: a window transfers on an edge where out_window_valid && window_req.
  - out_window_valid falls on that edge.
  - The next window's pop occurs no earlier than the following edge.
  - window_req high while valid = 0 has no effect.
- Throughput: at most one window per N+3 cycles.
- FIFO full: after DEPTH accepted-but-unpopped events, ready_for_new_event = 0 until a pop. It returns to 1 the cycle after the pop edge.
- Reset mid-operation: FIFO is flushed, FSM aborts to IDLE, out_window_valid drops, memory keeps its contents.

## Test plan
- H=1, DW=4: event (addr 0x0505, val 7) into empty memory → after 11 cycles, window addr 0x0505 with element 4 = 7 and all others 0.
- H=1: events 0x0404=1, 0x0405=2, 0x0406=3, then 0x0505=9 → fourth window has elements 0..2 = 1,2,3, element 4 = 9, rest 0. Windows come out in order 0x0404, 0x0405, 0x0406, 0x0505.
- Border, H=3, DW=14: event at 0x0000, val 0x3FFF → element 24 = 0x3FFF; rows/cols −3..−1 are 0; no wrap from row or col 255.
- Backpressure: hold window_req = 0 for 20 cycles with valid high → out_window_valid, value and addr stay stable. Raising window_req for one edge transfers exactly one window.
- FIFO full, DEPTH=4, window_req = 0: 6 back-to-back events → ready falls after 5 accepts (4 queued plus 1 popped). The sixth event is not written and produces no window.
- Assert rst_n = 1 during FETCH → next cycle valid = 0, FIFO empty, ready = 1. A previously written pixel is still read back in a new window.

Source files
------------

// File: rtl/event_window_scheduler_if.sv
// Event/window bus between the upstream event source, the window scheduler
// and the downstream kernel.
//   in_event_value/addr/valid : pixel event into the scheduler
//   ready_for_new_event       : scheduler can take an event this cycle
//   window_req                : downstream ready to take a window
//   out_window_value/addr/valid : packed window and its centre address
// master = event source / window consumer, slave = scheduler.
interface event_window_scheduler_if #(
  parameter int unsigned DATA_WIDTH       = 4,
  parameter int unsigned HALF_WINDOW_SIZE = 1
);
  localparam int unsigned WIN_SIDE = 2 * HALF_WINDOW_SIZE + 1;
  localparam int unsigned WIN_SIZE = WIN_SIDE * WIN_SIDE;

  logic [DATA_WIDTH-1:0]          in_event_value;
  logic [15:0]                    in_event_addr;
  logic                           in_event_valid;
  logic                           ready_for_new_event;
  logic                           window_req;
  logic [WIN_SIZE*DATA_WIDTH-1:0] out_window_value;
  logic [15:0]                    out_window_addr;
  logic                           out_window_valid;

  modport master (
    output in_event_value, in_event_addr, in_event_valid, window_req,
    input  ready_for_new_event, out_window_value, out_window_addr, out_window_valid
  );

  modport slave (
    input  in_event_value, in_event_addr, in_event_valid, window_req,
    output ready_for_new_event, out_window_value, out_window_addr, out_window_valid
  );
endinterface

// File: rtl/event_window_scheduler.sv
// Event-driven window scheduler: stores each pixel event in a 256x256 frame
// memory, queues its address as a window centre, then gathers the
// (2H+1)^2 neighbourhood of each queued centre and presents it downstream.
//   clk   : clock, rising edge
//   rst_n : synchronous reset, active HIGH (historical name)
//   bus   : event_window_scheduler_if.slave (event in, window out)
module event_window_scheduler #(
  parameter int unsigned DATA_WIDTH             = 4,
  parameter int unsigned HALF_WINDOW_SIZE       = 1,
  parameter int unsigned TODO_WINDOW_FIFO_DEPTH = 256
) (
  input logic                    clk,
  input logic                    rst_n,
  event_window_scheduler_if.slave bus
);
  localparam int unsigned WIN_SIDE = 2 * HALF_WINDOW_SIZE + 1;
  localparam int unsigned WIN_SIZE = WIN_SIDE * WIN_SIDE;
  localparam int unsigned IDX_W    = $clog2(WIN_SIZE + 1);
  localparam int unsigned SIDE_W   = $clog2(WIN_SIDE + 1);
  localparam int unsigned PTR_W    = $clog2(TODO_WINDOW_FIFO_DEPTH);
  localparam int unsigned CNT_W    = PTR_W + 1;
  localparam int unsigned COORD_W  = 10;

  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH, ST_DRAIN, ST_SETTLE, ST_VALID
  } state_t;

  state_t state, state_nxt;

  logic                  pop, push, rd_issue;
  logic                  fifo_full, fifo_empty;
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      fifo_cnt;
  logic [15:0]           fifo_mem [TODO_WINDOW_FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] frame_mem [65536];

  logic [SIDE_W-1:0]     rd_dr, rd_dc;
  logic [IDX_W-1:0]      rd_idx, rd_idx_q;
  logic                  rd_last, rd_oor, rd_oor_q, rd_vld_q;
  logic [15:0]           ctr_addr, rd_addr;
  logic [COORD_W-1:0]    nb_row, nb_col;
  logic [DATA_WIDTH-1:0] mem_q;

  // Centre-address FIFO; no push while full, even on a same-cycle pop
  assign fifo_full  = (fifo_cnt == CNT_W'(TODO_WINDOW_FIFO_DEPTH));
  assign fifo_empty = (fifo_cnt == '0);
  assign push       = bus.in_event_valid && !fifo_full;
  assign bus.ready_for_new_event = !fifo_full;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= bus.in_event_addr;
  end

  // Element 0 is read in the pop cycle, so the centre comes straight from the FIFO head
  assign ctr_addr = (state == ST_IDLE) ? fifo_mem[rd_ptr] : bus.out_window_addr;
  assign nb_row   = COORD_W'(ctr_addr[15:8]) + COORD_W'(rd_dr) - COORD_W'(HALF_WINDOW_SIZE);
  assign nb_col   = COORD_W'(ctr_addr[7:0])  + COORD_W'(rd_dc) - COORD_W'(HALF_WINDOW_SIZE);
  // Negative coordinates wrap to large values, so one upper-bit test covers both borders
  assign rd_oor   = (nb_row[COORD_W-1:8] != '0) || (nb_col[COORD_W-1:8] != '0);
  assign rd_addr  = {nb_row[7:0], nb_col[7:0]};
  assign rd_last  = (rd_idx == IDX_W'(WIN_SIZE - 1));

  // Frame memory: read-first, not cleared by reset
  always_ff @(posedge clk) begin
    if (push) frame_mem[bus.in_event_addr] <= bus.in_event_value;
    if (rd_issue && !rd_oor) mem_q <= frame_mem[rd_addr];
  end

  // Row-major neighbour counters; they rest at element 0 between windows
  always_ff @(posedge clk) begin
    if (rst_n) begin
      rd_dr  <= '0;
      rd_dc  <= '0;
      rd_idx <= '0;
    end else if (rd_issue) begin
      if (rd_last) begin
        rd_dr  <= '0;
        rd_dc  <= '0;
        rd_idx <= '0;
      end else begin
        rd_idx <= rd_idx + 1'b1;
        if (rd_dc == SIDE_W'(WIN_SIDE - 1)) begin
          rd_dc <= '0;
          rd_dr <= rd_dr + 1'b1;
        end else begin
          rd_dc <= rd_dc + 1'b1;
        end
      end
    end
  end

  // Read-data capture into the packed window, one element per cycle
  always_ff @(posedge clk) begin
    if (rst_n) begin
      bus.out_window_addr  <= '0;
      bus.out_window_value <= '0;
      rd_vld_q             <= 1'b0;
      rd_idx_q             <= '0;
      rd_oor_q             <= 1'b0;
    end else begin
      if (pop) bus.out_window_addr <= ctr_addr;
      rd_vld_q <= rd_issue;
      rd_idx_q <= rd_idx;
      rd_oor_q <= rd_oor;
      if (rd_vld_q)
        bus.out_window_value[32'(rd_idx_q) * DATA_WIDTH +: DATA_WIDTH] <=
          rd_oor_q ? '0 : mem_q;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst_n) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next state; SETTLE adds the spare cycle of the fixed N+2 event-to-window latency
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (!fifo_empty) state_nxt = rd_last ? ST_DRAIN : ST_FETCH;
      ST_FETCH:  if (rd_last) state_nxt = ST_DRAIN;
      ST_DRAIN:  state_nxt = ST_SETTLE;
      ST_SETTLE: state_nxt = ST_VALID;
      ST_VALID:  if (bus.window_req) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // State decode outputs
  always_comb begin
    pop                  = 1'b0;
    rd_issue             = 1'b0;
    bus.out_window_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        pop      = !fifo_empty;
        rd_issue = !fifo_empty;
      end
      ST_FETCH: rd_issue             = 1'b1;
      ST_VALID: bus.out_window_valid = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_event_window_scheduler.sv
// Scoreboard bench: instance A (H=1, DW=4, DEPTH=4) and instance B (H=3, DW=14).
module tb_event_window_scheduler;
  localparam int unsigned A_WV = 9 * 4;
  localparam int unsigned B_WV = 49 * 14;

  typedef struct packed {
    logic [15:0]     addr;
    logic [A_WV-1:0] val;
  } a_exp_t;

  typedef struct packed {
    logic [15:0]     addr;
    logic [B_WV-1:0] val;
  } b_exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  a_exp_t a_q[$];
  b_exp_t b_q[$];

  always #5 clk = ~clk;

  event_window_scheduler_if #(.DATA_WIDTH(4),  .HALF_WINDOW_SIZE(1)) a_if ();
  event_window_scheduler_if #(.DATA_WIDTH(14), .HALF_WINDOW_SIZE(3)) b_if ();

  event_window_scheduler #(
    .DATA_WIDTH(4), .HALF_WINDOW_SIZE(1), .TODO_WINDOW_FIFO_DEPTH(4)
  ) u_a (.clk(clk), .rst_n(rst_n), .bus(a_if.slave));

  event_window_scheduler #(
    .DATA_WIDTH(14), .HALF_WINDOW_SIZE(3), .TODO_WINDOW_FIFO_DEPTH(256)
  ) u_b (.clk(clk), .rst_n(rst_n), .bus(b_if.slave));

  // Monitors: every presented window must match the scoreboard head
  always @(negedge clk) begin
    if (!rst_n && a_if.out_window_valid) begin
      total++;
      if (a_q.size() == 0) begin
        bad++;
        $display("FAIL a_unexpected_window addr=%h val=%h", a_if.out_window_addr, a_if.out_window_value);
      end else begin
        if (a_if.out_window_addr !== a_q[0].addr || a_if.out_window_value !== a_q[0].val) begin
          bad++;
          $display("FAIL a_window got addr=%h val=%h want addr=%h val=%h",
                   a_if.out_window_addr, a_if.out_window_value, a_q[0].addr, a_q[0].val);
        end
        if (a_if.window_req) void'(a_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n && b_if.out_window_valid) begin
      total++;
      if (b_q.size() == 0) begin
        bad++;
        $display("FAIL b_unexpected_window addr=%h", b_if.out_window_addr);
      end else begin
        if (b_if.out_window_addr !== b_q[0].addr || b_if.out_window_value !== b_q[0].val) begin
          bad++;
          $display("FAIL b_window got addr=%h val=%h want addr=%h val=%h",
                   b_if.out_window_addr, b_if.out_window_value, b_q[0].addr, b_q[0].val);
        end
        if (b_if.window_req) void'(b_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic send_a(input logic [15:0] addr, input logic [3:0] val,
                        input bit expect_win, input logic [A_WV-1:0] exp_val);
    a_if.in_event_addr  = addr;
    a_if.in_event_value = val;
    a_if.in_event_valid = 1'b1;
    if (expect_win) a_q.push_back('{addr: addr, val: exp_val});
    @(posedge clk); #1;
    a_if.in_event_valid = 1'b0;
  endtask

  task automatic send_b(input logic [15:0] addr, input logic [13:0] val);
    logic [B_WV-1:0] e;
    e = '0;
    e[24*14 +: 14] = val;
    b_if.in_event_addr  = addr;
    b_if.in_event_value = val;
    b_if.in_event_valid = 1'b1;
    b_q.push_back('{addr: addr, val: e});
    @(posedge clk); #1;
    b_if.in_event_valid = 1'b0;
  endtask

  task automatic drain_a(input string name);
    int n = 0;
    while ((a_q.size() != 0 || a_if.out_window_valid) && n < 400) begin
      @(posedge clk); #1; n++;
    end
    check(name, 64'(n < 400), 64'd1);
  endtask

  task automatic drain_b(input string name);
    int n = 0;
    while ((b_q.size() != 0 || b_if.out_window_valid) && n < 800) begin
      @(posedge clk); #1; n++;
    end
    check(name, 64'(n < 800), 64'd1);
  endtask

  task automatic measure(input bit use_b, output int lat);
    lat = 0;
    while (!(use_b ? b_if.out_window_valid : a_if.out_window_valid) && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  initial begin
    int lat;
    rst_n = 1'b1;
    a_if.in_event_valid = 1'b0; a_if.in_event_addr = '0; a_if.in_event_value = '0; a_if.window_req = 1'b0;
    b_if.in_event_valid = 1'b0; b_if.in_event_addr = '0; b_if.in_event_value = '0; b_if.window_req = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;

    // Reset values
    check("rst_a_valid", 64'(a_if.out_window_valid), 64'd0);
    check("rst_a_addr",  64'(a_if.out_window_addr), 64'd0);
    check("rst_a_value", 64'(a_if.out_window_value), 64'd0);
    check("rst_a_ready", 64'(a_if.ready_for_new_event), 64'd1);
    check("rst_b_valid", 64'(b_if.out_window_valid), 64'd0);
    check("rst_b_ready", 64'(b_if.ready_for_new_event), 64'd1);

    // Single event into empty memory, latency N+2
    a_if.window_req = 1'b1;
    send_a(16'h0505, 4'h7, 1'b1, 36'h000070000);
    measure(1'b0, lat);
    check("a_latency_h1", 64'(lat), 64'd11);
    drain_a("a_drain_single");

    // Four back-to-back events; all writes land before their pixels are read
    send_a(16'h0404, 4'h1, 1'b1, 36'h900210000);
    send_a(16'h0405, 4'h2, 1'b1, 36'h090321000);
    send_a(16'h0406, 4'h3, 1'b1, 36'h009032000);
    send_a(16'h0505, 4'h9, 1'b1, 36'h000090321);
    drain_a("a_drain_four");

    // Backpressure: held window stays stable, one req edge moves exactly one window
    a_if.window_req = 1'b0;
    send_a(16'h0808, 4'h5, 1'b1, 36'h000050000);
    measure(1'b0, lat);
    check("a_bp_valid_up", 64'(a_if.out_window_valid), 64'd1);
    repeat (20) begin @(posedge clk); #1; end
    check("a_bp_valid_held", 64'(a_if.out_window_valid), 64'd1);
    a_if.window_req = 1'b1;
    @(posedge clk); #1;
    a_if.window_req = 1'b0;
    check("a_bp_valid_drop", 64'(a_if.out_window_valid), 64'd0);
    check("a_bp_queue_empty", 64'(a_q.size()), 64'd0);
    repeat (15) begin @(posedge clk); #1; end

    // Reset during FETCH aborts the window but keeps memory
    a_if.window_req = 1'b1;
    send_a(16'h0909, 4'hA, 1'b1, 36'h0000A0005);
    drain_a("a_drain_pre_reset");
    send_a(16'h0A0A, 4'h3, 1'b0, '0);
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    check("a_rst_mid_valid", 64'(a_if.out_window_valid), 64'd0);
    check("a_rst_mid_ready", 64'(a_if.ready_for_new_event), 64'd1);
    check("a_rst_mid_addr",  64'(a_if.out_window_addr), 64'd0);
    repeat (20) begin @(posedge clk); #1; end
    send_a(16'h0A09, 4'h4, 1'b1, 36'h0003400A0);
    drain_a("a_drain_post_reset");

    // FIFO full with DEPTH=4: five accepts (one popped), sixth dropped
    a_if.window_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      a_if.in_event_addr  = 16'(16'h2020 + i * 16'h1010);
      a_if.in_event_value = 4'(i + 1);
      a_if.in_event_valid = 1'b1;
      check($sformatf("a_ready_ev%0d", i), 64'(a_if.ready_for_new_event), (i < 5) ? 64'd1 : 64'd0);
      if (i < 5) a_q.push_back('{addr: 16'(16'h2020 + i * 16'h1010), val: A_WV'(i + 1) << 16});
      @(posedge clk); #1;
    end
    a_if.in_event_valid = 1'b0;
    repeat (15) begin @(posedge clk); #1; end
    check("a_ready_held_full", 64'(a_if.ready_for_new_event), 64'd0);
    a_if.window_req = 1'b1;
    @(posedge clk); #1;
    check("a_ready_at_xfer", 64'(a_if.ready_for_new_event), 64'd0);
    @(posedge clk); #1;
    check("a_ready_after_pop", 64'(a_if.ready_for_new_event), 64'd1);
    drain_a("a_drain_full");
    // Neighbour 0x7070 (element 3) must still be 0: the dropped event was not written
    send_a(16'h7071, 4'h1, 1'b1, 36'h000010000);
    drain_a("a_drain_dropped");

    // Border windows, H=3: no wrap-around from row/col 255
    b_if.window_req = 1'b1;
    send_b(16'hFFFF, 14'h1234);
    measure(1'b1, lat);
    check("b_latency_h3", 64'(lat), 64'd51);
    send_b(16'h00FF, 14'h0111);
    send_b(16'hFF00, 14'h0222);
    send_b(16'h0000, 14'h3FFF);
    drain_b("b_drain_border");

    repeat (10) begin @(posedge clk); #1; end
    check("a_final_queue", 64'(a_q.size()), 64'd0);
    check("b_final_queue", 64'(b_q.size()), 64'd0);
    check("a_final_ready", 64'(a_if.ready_for_new_event), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
